// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM states, HTRANS codes and the APB address map for modport_bridge.
package bridge_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SETUP, S_ACCESS, S_ERR} state_e;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;
  localparam logic [2:0] PSEL_SLV0 = 3'b001;
  localparam logic [2:0] PSEL_SLV1 = 3'b010;
  localparam logic [2:0] PSEL_SLV2 = 3'b100;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: combinational HADDR to one-hot PSELX decode with an unmapped flag.
module apb_addr_decode
  import bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 3
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               unmapped_o
);
  logic [31:0] a;
  assign a = 32'(addr_i);
  assign sel_o = (a >= SLV0_BASE && a <= SLV0_LIMIT) ? NUM_SLV'(PSEL_SLV0) :
                 (a >= SLV1_BASE && a <= SLV1_LIMIT) ? NUM_SLV'(PSEL_SLV1) :
                 (a >= SLV2_BASE && a <= SLV2_LIMIT) ? NUM_SLV'(PSEL_SLV2) : '0;
  assign unmapped_o = ~|sel_o;
endmodule

// File: rtl/modport_bridge.sv
// modport_bridge: AHB-Lite slave to APB master bridge, one APB setup/access per AHB transfer.
// Define MODPORT_BRIDGE_ERR_RESP_EN to answer unmapped transfers with a two-cycle AHB ERROR.
module modport_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               HSEL,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic               HREADYin,
  output logic               HREADYout,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               HRESP,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [DATA_W-1:0]  PWDATA,
  output logic               PWRITE,
  output logic [NUM_SLV-1:0] PSELX,
  output logic               PENABLE,
  input  logic [DATA_W-1:0]  PRDATA
);
  state_e state_q, state_d;
  logic [NUM_SLV-1:0] dec_sel, sel_q, psel_q;
  logic [ADDR_W-1:0] addr_q, paddr_q;
  logic [DATA_W-1:0] pwdata_q, hrdata_q;
  logic dec_unm, unm_q, write_q, pwrite_q, penable_q, valid, err_go, err2_q;
  apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
    .addr_i    (HADDR),
    .sel_o     (dec_sel),
    .unmapped_o(dec_unm)
  );
  assign valid = HSEL & HREADYin & (HTRANS != HTRANS_IDLE) & (HTRANS != HTRANS_BUSY)
               & (state_q == S_IDLE);
`ifdef MODPORT_BRIDGE_ERR_RESP_EN
  // Second ERROR cycle: HREADYout rises while HRESP stays high.
  always_ff @(posedge clk) err2_q <= rst ? 1'b0 : (state_q == S_ERR) & ~err2_q;
  assign err_go    = dec_unm;
  assign HRESP     = state_q == S_ERR;
  assign HREADYout = (state_q == S_IDLE) | ((state_q == S_ERR) & err2_q);
`else
  assign err2_q    = 1'b0;
  assign err_go    = 1'b0;
  assign HRESP     = 1'b0;
  assign HREADYout = state_q == S_IDLE;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = valid ? (err_go ? S_ERR : S_CAPTURE) : S_IDLE;
      S_CAPTURE: state_d = S_SETUP;
      S_SETUP:   state_d = S_ACCESS;
      S_ACCESS:  state_d = S_IDLE;
      S_ERR:     state_d = err2_q ? S_IDLE : S_ERR;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      unm_q     <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (valid) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        sel_q   <= dec_sel;
        unm_q   <= dec_unm;
      end
      // CAPTURE is the AHB data phase, so HWDATA is valid here.
      if (state_q == S_CAPTURE) begin
        paddr_q  <= addr_q;
        pwrite_q <= write_q;
        pwdata_q <= HWDATA;
      end
      psel_q    <= (state_q == S_CAPTURE || state_q == S_SETUP) ? sel_q : '0;
      penable_q <= state_q == S_SETUP;
      if (state_q == S_ACCESS && !write_q) hrdata_q <= unm_q ? '0 : PRDATA;
    end
  end
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PSELX   = psel_q;
  assign PENABLE = penable_q;
  assign HRDATA  = hrdata_q;
endmodule

// File: tb/tb_modport_bridge.sv
// tb_modport_bridge: randomized transaction-level check of modport_bridge against an address-map model.
module tb_modport_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic HSEL = 1'b0, HWRITE = 1'b0, HREADYin = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0, PRDATA = '0;
  logic [1:0] HTRANS = 2'b00;
  logic HREADYout, HRESP, PWRITE, PENABLE;
  logic [31:0] HRDATA, PADDR, PWDATA;
  logic [2:0] PSELX;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] e_hrdata = '0, e_paddr = '0, e_pwdata = '0;
  logic e_pwrite = 1'b0;
  modport_bridge dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADYin(HREADYin), .HREADYout(HREADYout), .HRDATA(HRDATA),
    .HRESP(HRESP), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELX(PSELX),
    .PENABLE(PENABLE), .PRDATA(PRDATA)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] map(input logic [31:0] a);
    if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
    return 3'(3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".rdy"}, 32'(HREADYout), 1);
    chk({tag, ".psel"}, 32'(PSELX), 0);
    chk({tag, ".pen"}, 32'(PENABLE), 0);
    chk({tag, ".hresp"}, 32'(HRESP), 0);
    chk({tag, ".hrdata"}, HRDATA, e_hrdata);
    chk({tag, ".paddr"}, PADDR, e_paddr);
    chk({tag, ".pwrite"}, 32'(PWRITE), 32'(e_pwrite));
    chk({tag, ".pwdata"}, PWDATA, e_pwdata);
  endtask
  task automatic reset_chk(input string tag);
    e_hrdata = '0; e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
    idle_chk(tag);
  endtask
  // Drives one transfer from an IDLE cycle and checks every cycle until the bridge is IDLE again.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [31:0] rd);
    logic [2:0] sel;
    sel = map(a);
    chk("accept.rdy", 32'(HREADYout), 1);
    HSEL = 1'b1; HADDR = a; HTRANS = ($urandom_range(1) != 0) ? 2'b10 : 2'b11;
    HWRITE = wr; HREADYin = 1'b1; PRDATA = rd; HWDATA = $urandom;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = ~wr; HWDATA = wd;
`ifdef MODPORT_BRIDGE_ERR_RESP_EN
    if (sel == 3'b000) begin
      chk("err1.hresp", 32'(HRESP), 1);
      chk("err1.rdy", 32'(HREADYout), 0);
      chk("err1.psel", 32'(PSELX), 0);
      tick();
      chk("err2.hresp", 32'(HRESP), 1);
      chk("err2.rdy", 32'(HREADYout), 1);
      chk("err2.psel", 32'(PSELX), 0);
      tick();
      idle_chk("err_done");
      return;
    end
`endif
    chk("cap.rdy", 32'(HREADYout), 0);
    chk("cap.psel", 32'(PSELX), 0);
    chk("cap.pen", 32'(PENABLE), 0);
    chk("cap.paddr", PADDR, e_paddr);
    tick();
    HWDATA = $urandom;
    e_paddr = a; e_pwrite = wr; e_pwdata = wd;
    chk("setup.rdy", 32'(HREADYout), 0);
    chk("setup.psel", 32'(PSELX), 32'(sel));
    chk("setup.pen", 32'(PENABLE), 0);
    chk("setup.paddr", PADDR, a);
    chk("setup.pwrite", 32'(PWRITE), 32'(wr));
    if (wr) chk("setup.pwdata", PWDATA, wd);
    tick();
    chk("access.rdy", 32'(HREADYout), 0);
    chk("access.psel", 32'(PSELX), 32'(sel));
    chk("access.pen", 32'(PENABLE), 1);
    chk("access.paddr", PADDR, a);
    tick();
    PRDATA = $urandom;
    if (!wr) e_hrdata = (sel == 3'b000) ? 32'h0 : rd;
    if (wr) e_pwdata = PWDATA;
    idle_chk("done");
    if (wr) chk("done.pwdata", PWDATA, wd);
  endtask
  // Idle cycles with HSEL/HTRANS/HREADYin combinations that must not start a transfer.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      HSEL = 1'($urandom); HADDR = 32'h8000_0000 + 32'($urandom_range(3)) * 32'h0400_0000;
      HWRITE = 1'($urandom);
      if ($urandom_range(2) == 0) begin
        HTRANS = 2'b10; HREADYin = 1'b0;
      end else begin
        HTRANS = 2'($urandom_range(1)); HREADYin = 1'b1;
      end
      tick();
      idle_chk("gap");
    end
    HSEL = 1'b0; HTRANS = 2'b00; HREADYin = 1'b1;
  endtask
  initial begin
    logic [31:0] a;
    logic [31:0] bnd [6];
    bnd[0] = 32'h83FF_FFFF; bnd[1] = 32'h8400_0000; bnd[2] = 32'h87FF_FFFC;
    bnd[3] = 32'h8BFF_FFFF; bnd[4] = 32'h8C00_0000; bnd[5] = 32'h7FFF_FFFF;
    tick(); tick();
    reset_chk("reset");
    rst = 1'b0;
    tick();
    idle_chk("post_reset");
    xfer(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0);
    xfer(32'h8400_0020, 1'b0, 32'h0, 32'h1234_5678);
    xfer(32'h8800_0000, 1'b0, 32'h0, 32'hCAFE_F00D);
    gap(4);
    xfer(32'h8000_0000, 1'b1, 32'hA5A5_0001, 32'h0);
    xfer(32'h8400_0000, 1'b0, 32'h0, 32'h5A5A_0002);
    xfer(32'h9000_0000, 1'b0, 32'h0, 32'hFFFF_FFFF);
    xfer(32'h9000_0000, 1'b1, 32'h1111_2222, 32'h0);
    for (int i = 0; i < 6; i++) xfer(bnd[i], 1'($urandom), $urandom, $urandom);
    HSEL = 1'b1; HADDR = 32'h8400_0040; HTRANS = 2'b10; HWRITE = 1'b1;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h7777_7777;
    tick();
    chk("mid.psel", 32'(PSELX), 32'h2);
    rst = 1'b1;
    tick();
    reset_chk("mid_reset");
    rst = 1'b0;
    tick();
    idle_chk("after_mid_reset");
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(4) == 0) ? 32'($urandom)
        : 32'h8000_0000 + 32'($urandom_range(2)) * 32'h0400_0000 + 32'($urandom_range(32'h03FF_FFFF));
      xfer(a, 1'($urandom), $urandom, $urandom);
      if ($urandom_range(1) != 0) gap($urandom_range(2, 1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
